// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron blocks: default widths, decay
// parameters, the weight type and an unsigned saturating clamp.
package snn_pkg;

  localparam int W_DEF            = 8;
  localparam int DECAY_SHIFT_DEF  = 3;
  localparam int DECAY_PERIOD_DEF = 4;

  typedef logic signed [W_DEF-1:0] weight_t;

  // Clamp a signed sum into [0, 2^bits-1]; clamped reports whether a bound was hit.
  function automatic logic [31:0] clamp_u(input logic signed [31:0] s,
                                          input int bits,
                                          output logic clamped);
    logic signed [31:0] hi;
    hi      = (32'sd1 <<< bits) - 32'sd1;
    clamped = 1'b0;
    if (s < 0) begin
      clamped = 1'b1;
      return '0;
    end
    if (s > hi) begin
      clamped = 1'b1;
      return hi;
    end
    return s;
  endfunction

endpackage

// File: rtl/decay_ticker.sv
// Modulo-PERIOD counter; tick is high in the last cycle of each period.
module decay_ticker #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = (cnt_reg == CW'(PERIOD - 1));

endmodule

// File: rtl/lif_synapse.sv
// Synaptic current generator: per-input signed weights accumulated into an
// unsigned saturating current with periodic exponential decay.
module lif_synapse
  import snn_pkg::*;
#(
  parameter int N_IN         = 3,
  parameter int W            = W_DEF,
  parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF,
  parameter int DECAY_PERIOD = DECAY_PERIOD_DEF,
  parameter int WEIGHT_INIT  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] spike_in,
  input  logic            wr_en,
  input  logic [1:0]      wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            sat_clr,
  output logic [W-1:0]    isyn,
  output logic            active,
  output logic            sat
);

  localparam int SW = W + 4;
  localparam logic [W-1:0] W_INIT = W'(WEIGHT_INIT);

  logic [N_IN-1:0][W-1:0]  w_reg;
  logic [N_IN-1:0][SW-1:0] contrib;
  logic [W-1:0]            cur_reg;
  logic [W-1:0]            cur_next;
  logic [W-1:0]            dec_step;
  logic [W-1:0]            decayed;
  logic [W-1:0]            d_cur;
  logic signed [SW-1:0]    sum_next;
  logic                    clamp_hit;
  logic                    active_reg;
  logic                    sat_reg;
  logic                    tick;

  decay_ticker #(.PERIOD(DECAY_PERIOD)) u_ticker (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) w_reg[i] <= W_INIT;
    end else if (wr_en) begin
      for (int i = 0; i < N_IN; i++) begin
        if (wr_addr == 2'(i)) w_reg[i] <= wr_data;
      end
    end
  end

  // Sign-extend each spiking input's weight into the wide accumulator.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_contrib
      assign contrib[gi] = spike_in[gi] ? {{4{w_reg[gi][W-1]}}, w_reg[gi]} : '0;
    end
  endgenerate

  always_comb begin
    dec_step = cur_reg >> DECAY_SHIFT;
    if (dec_step != '0) begin
      decayed = cur_reg - dec_step;
    end else if (cur_reg != '0) begin
      // Small currents still step down by one so the tail always reaches zero.
      decayed = cur_reg - W'(1);
    end else begin
      decayed = '0;
    end
    d_cur    = tick ? decayed : cur_reg;
    sum_next = {4'b0000, d_cur};
    for (int i = 0; i < N_IN; i++) sum_next = sum_next + contrib[i];
    clamp_hit = 1'b0;
    cur_next  = W'(clamp_u(32'(sum_next), W, clamp_hit));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_reg    <= '0;
      active_reg <= 1'b0;
      sat_reg    <= 1'b0;
    end else begin
      cur_reg    <= cur_next;
      active_reg <= (cur_next != '0);
      sat_reg    <= clamp_hit | (sat_reg & ~sat_clr);
    end
  end

  assign isyn   = cur_reg;
  assign active = active_reg;
  assign sat    = sat_reg;

endmodule

// File: tb/tb_lif_synapse.sv
// Directed-vector bench for lif_synapse with hand-computed expected currents.
module tb_lif_synapse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] spike_in;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       sat_clr;
  logic [7:0] isyn;
  logic       active;
  logic       sat;

  int n_checks = 0;
  int n_pass   = 0;
  int ph       = 0;  // counter value the next rising edge will see

  lif_synapse dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spike_in (spike_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sat_clr  (sat_clr),
    .isyn     (isyn),
    .active   (active),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
      $display("ok   %s: %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    spike_in = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    sat_clr  = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    ph    = 0;
  endtask

  task automatic write_w(input logic [1:0] a, input logic [7:0] dt);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = dt;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] s);
    spike_in = s;
    cycle();
    spike_in = '0;
  endtask

  task automatic run_to_tick();
    while (ph != 3) cycle();
    cycle();
  endtask

  initial begin
    // Reset values, then default weight on input 2
    do_reset();
    check_eq("rst_isyn", isyn, 0);
    check_eq("rst_active", active, 0);
    check_eq("rst_sat", sat, 0);
    pulse(3'b100);
    check_eq("init_w2_isyn", isyn, 16);
    check_eq("init_w2_active", active, 1);

    // Out-of-range write is ignored: all three weights stay at 16
    do_reset();
    write_w(2'd3, 8'd100);
    pulse(3'b111);
    check_eq("oor_write_isyn", isyn, 48);

    // Write and decay
    do_reset();
    write_w(2'd0, 8'd40);
    pulse(3'b001);
    check_eq("w0_40_isyn", isyn, 40);
    cycle();
    check_eq("pre_tick_hold", isyn, 40);
    run_to_tick();
    check_eq("decay_35", isyn, 35);
    run_to_tick();
    check_eq("decay_31", isyn, 31);
    run_to_tick();
    check_eq("decay_28", isyn, 28);
    run_to_tick();
    check_eq("decay_25", isyn, 25);

    // Positive saturation, sticky flag, clear, set-beats-clear
    do_reset();
    write_w(2'd0, 8'd100);
    write_w(2'd1, 8'd100);
    write_w(2'd2, 8'd100);
    pulse(3'b111);
    check_eq("possat_isyn", isyn, 255);
    check_eq("possat_sat", sat, 1);
    cycle();
    check_eq("sat_sticky1", sat, 1);
    cycle();
    check_eq("sat_sticky2", sat, 1);
    sat_clr = 1'b1;
    cycle();
    check_eq("sat_cleared", sat, 0);
    pulse(3'b111);
    sat_clr = 1'b0;
    check_eq("sat_set_wins", sat, 1);
    check_eq("sat_set_wins_isyn", isyn, 255);

    // Inhibition floor
    do_reset();
    write_w(2'd0, 8'd20);
    spike_in = 3'b001;
    write_w(2'd1, 8'hCE);  // -50
    spike_in = '0;
    check_eq("inh_pre_isyn", isyn, 20);
    check_eq("inh_pre_sat", sat, 0);
    pulse(3'b010);
    check_eq("inh_isyn", isyn, 0);
    check_eq("inh_active", active, 0);
    check_eq("inh_sat", sat, 1);

    // Decay tail reaches zero and holds
    do_reset();
    write_w(2'd0, 8'd5);
    pulse(3'b001);
    check_eq("tail_start", isyn, 5);
    run_to_tick();
    check_eq("tail_4", isyn, 4);
    run_to_tick();
    check_eq("tail_3", isyn, 3);
    run_to_tick();
    check_eq("tail_2", isyn, 2);
    run_to_tick();
    check_eq("tail_1", isyn, 1);
    run_to_tick();
    check_eq("tail_0", isyn, 0);
    check_eq("tail_0_active", active, 0);
    repeat (8) cycle();
    check_eq("tail_hold", isyn, 0);
    check_eq("tail_no_sat", sat, 0);

    // Write colliding with a spike uses the old weight; new one applies next cycle
    do_reset();
    spike_in = 3'b001;
    write_w(2'd0, 8'd80);
    spike_in = '0;
    check_eq("coll_old_w", isyn, 16);
    pulse(3'b001);
    check_eq("coll_new_w", isyn, 96);
    run_to_tick();
    check_eq("coll_decay", isyn, 84);

    // Asynchronous reset mid-decay, with a write pending that must be lost
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_data = 8'd99;
    #1;
    check_eq("async_rst_isyn", isyn, 0);
    check_eq("async_rst_active", active, 0);
    cycle();
    cycle();
    wr_en = 1'b0;
    rst_n = 1'b1;
    ph    = 0;
    pulse(3'b001);
    check_eq("rst_w0_restored", isyn, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lif_synapse.md
# lif_synapse

Synaptic current generator that sits directly upstream of each LIF neuron and drives its 8-bit `Isyn` input. It accepts up to `N_IN` single-bit presynaptic spike lines (pads, or spike outputs of other neurons), adds a programmable signed weight per spiking input to an unsigned current register, and applies periodic exponential decay. Weights are written through a simple single-cycle write port from the top level.

## Interface
- `N_IN`, 3: number of presynaptic spike inputs (1..4)
- `W`, 8: width of the current and the weights
- `DECAY_SHIFT`, 3: decay factor; each decay step removes `cur >> DECAY_SHIFT`
- `DECAY_PERIOD`, 4: cycles between decay steps (≥1)
- `WEIGHT_INIT`, 16: reset value of every weight (signed, W bits)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `spike_in`  in  N_IN  presynaptic spikes, sampled each cycle, level = one event per cycle high
- `wr_en`  in  1  weight write strobe, one write per cycle
- `wr_addr`  in  2  weight index (0..N_IN-1); out-of-range writes ignored
- `wr_data`  in  W  signed two's-complement weight
- `sat_clr`  in  1  clears the sticky `sat` flag
- `isyn`  out  W  registered synaptic current, unsigned, to neuron `Isyn`
- `active`  out  1  registered, high when `isyn != 0`
- `sat`  out  1  sticky: set when any update clamped at either bound

## Operation
- State: `cur` (W-bit unsigned), `w[N_IN]` (W-bit signed), decay counter, `sat`.
- Decay tick: counter runs 0..DECAY_PERIOD-1 and wraps; `tick` is high in the cycle where counter == DECAY_PERIOD-1.
- Per cycle, in this order:
  - `d = tick ? decay(cur) : cur`
  - `decay(c) = c - (c >> DECAY_SHIFT)` if `(c >> DECAY_SHIFT) != 0`; else `c - 1` if `c != 0`; else 0. The current always reaches 0.
  - `s = d + Σ w[i]` over i with `spike_in[i]=1`, computed signed in W+4 bits with no overflow.
  - `cur_next = clamp(s, 0, 2^W-1)`; if clamp active, `sat` is set.
- `sat` priority: setting in the same cycle as `sat_clr` wins (flag stays 1).
- Weight write: `w[wr_addr] <= wr_data` at the clock edge. A spike in the same cycle uses the old weight.
- No spikes and `cur=0`: `cur` stays 0, no sat.

## Timing
- Reset (async assert, sync-safe release): `cur=0`, `isyn=0`, `active=0`, `sat=0`, counter=0, all `w=WEIGHT_INIT`.
- The first `tick` occurs in cycle DECAY_PERIOD-1 after reset release, then every DECAY_PERIOD cycles.
- Spike-to-`isyn` latency: 1 cycle (`isyn` = `cur` register). `active` and `sat` update on the same edge.
- Weight write latency: 1 cycle; earliest use is a spike in the following cycle.
- Reset mid-operation: all state returns to reset values immediately, and pending writes are lost.
- Spikes on a tick cycle: decay applies first, then the weights are added.

## Structure
- Shared package `snn_pkg`: `W` default (8), the signed weight typedef, the `clamp_u` saturating function, and the default `DECAY_SHIFT`/`DECAY_PERIOD`. LIF neuron blocks use the same package.
- One sub-module, `decay_ticker`: a parameterised modulo-`DECAY_PERIOD` counter that outputs `tick`. It is reused by the neuron leak path.
- Weight file, adder tree and clamp stay inline.

## Test plan
All scenarios use the defaults (W=8, SHIFT=3, PERIOD=4, INIT=16).
- Reset: hold `rst_n`=0 for 3 cycles, then release → `isyn`=0, `active`=0, `sat`=0. A pulse on `spike_in[2]` in a non-tick cycle gives `isyn`=16 one cycle later.
- Write and decay: write `w0`=40, then pulse `spike_in[0]` in a non-tick cycle → `isyn`=40. Next tick → 35, following ticks → 31, 28, 25.
- Positive saturation: `w0`=`w1`=`w2`=100, pulse `spike_in`=3'b111 → `isyn`=255, `sat`=1. `sat` stays 1 until `sat_clr`, then goes to 0.
- Inhibition floor: `isyn`=20, `w1`=-50, pulse `spike_in[1]` → `isyn`=0, `active`=0, `sat`=1.
- Decay tail: `isyn`=5 with no spikes → 4, 3, 2, 1, 0 on consecutive ticks, 4 cycles apart. It then holds at 0.
- Collisions:
  - Write `w0`=80 in the same cycle as a `spike_in[0]` pulse with old `w0`=16 → `isyn` rises by 16.
  - Assert `rst_n` low mid-decay → `isyn`=0 immediately, and weights return to 16.
